// File: rtl/flick_conditioner.sv
// ---------------------------------------------------------------------------
// flick_conditioner
//
// Input stage for the flick button in front of Bound_Flasher. The raw button
// is asynchronous to clk and may bounce. This block synchronises it, debounces
// it with a four-state qualifier, and produces a single-cycle pulse for every
// accepted press. Bound_Flasher uses that pulse in place of the raw button.
// The debounced level and a wrapping press counter are also exported for debug.
//
// Parameters
//   SYNC_STAGES  flip-flops in the input synchroniser chain (>= 2)
//   DEB_CYCLES   consecutive equal synchronised samples needed to accept a
//                level change (>= 1)
//   CNT_W        width of press_count
//
// Ports
//   clk          in   1      system clock, rising-edge active
//   reset        in   1      synchronous reset, active low
//   flick        in   1      raw button, asynchronous, may bounce
//   pulse_flick  out  1      one-cycle pulse per accepted press (rising edge)
//   flick_level  out  1      debounced button level
//   press_count  out  CNT_W  accepted presses, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module flick_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flick,
    output logic             pulse_flick,
    output logic             flick_level,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned   DW       = $clog2(DEB_CYCLES + 1);
    // Count value on which the last qualifying sample is taken.
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // debounced level 0
        RISE = 2'd1,  // qualifying a 1
        HIGH = 2'd2,  // debounced level 1
        FALL = 2'd3   // qualifying a 0
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fs;
    logic [DW-1:0]          deb_cnt;
    logic [DW-1:0]          deb_cnt_nx;
    logic                   pulse_nx;

    // Synchroniser: the only logic that reads the raw button.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], flick};
        end
    end

    assign fs = sync_q[SYNC_STAGES-1];

    // State, debounce counter, registered pulse and press counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            pulse_flick <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nx;
            deb_cnt     <= deb_cnt_nx;
            pulse_flick <= pulse_nx;
            if (pulse_nx) begin
                press_count <= press_count + CNT_W'(1);
            end
        end
    end

    // Next-state logic. A pulse is requested only on entry to HIGH from the
    // low side, and HIGH can never request one, so pulses are never adjacent.
    always_comb begin
        state_nx   = state;
        deb_cnt_nx = deb_cnt;
        pulse_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (fs) begin
                    if (DEB_CYCLES == 1) begin
                        state_nx   = HIGH;
                        deb_cnt_nx = '0;
                        pulse_nx   = 1'b1;
                    end else begin
                        state_nx   = RISE;
                        deb_cnt_nx = DW'(1);
                    end
                end
            end
            RISE: begin
                if (!fs) begin
                    // Glitch rejected, no pulse.
                    state_nx   = IDLE;
                    deb_cnt_nx = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx   = HIGH;
                    deb_cnt_nx = '0;
                    pulse_nx   = 1'b1;
                end else begin
                    deb_cnt_nx = deb_cnt + DW'(1);
                end
            end
            HIGH: begin
                if (!fs) begin
                    if (DEB_CYCLES == 1) begin
                        state_nx   = IDLE;
                        deb_cnt_nx = '0;
                    end else begin
                        state_nx   = FALL;
                        deb_cnt_nx = DW'(1);
                    end
                end
            end
            FALL: begin
                if (fs) begin
                    // Release bounce: back to HIGH without a new press.
                    state_nx   = HIGH;
                    deb_cnt_nx = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx   = IDLE;
                    deb_cnt_nx = '0;
                end else begin
                    deb_cnt_nx = deb_cnt + DW'(1);
                end
            end
            default: begin
                state_nx   = IDLE;
                deb_cnt_nx = '0;
            end
        endcase
    end

    assign flick_level = (state == HIGH) || (state == FALL);

endmodule

// File: tb/tb_flick_conditioner.sv
// ---------------------------------------------------------------------------
// tb_flick_conditioner
//
// Directed bench for flick_conditioner with default parameters. Stimulus
// pushes the expected (cycle, press_count) of every pulse into a queue; a
// negedge monitor pops an entry whenever pulse_flick is high and compares.
// Cycle numbers are the count of rising clk edges seen so far.
// ---------------------------------------------------------------------------
module tb_flick_conditioner;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DEB_CYCLES  = 4;
    localparam int unsigned CNT_W       = 8;
    // Drive after edge N -> sampled at edge N+1 -> pulse seen after edge
    // N+1+SYNC_STAGES+DEB_CYCLES-1.
    localparam int LAT = SYNC_STAGES + DEB_CYCLES;

    logic             clk = 1'b0;
    logic             reset;
    logic             flick;
    logic             pulse_flick;
    logic             flick_level;
    logic [CNT_W-1:0] press_count;

    typedef struct {
        int               at;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_pulse = 1'b0;

    flick_conditioner #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flick      (flick),
        .pulse_flick(pulse_flick),
        .flick_level(flick_level),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_pulse(int at, logic [CNT_W-1:0] cnt);
        exp_t e;
        e.at  = at;
        e.cnt = cnt;
        q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (pulse_flick === 1'b1) begin
            check("pulse_width", {31'd0, prev_pulse}, 32'd0);
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.at);
                check("pulse_count", {24'd0, press_count}, {24'd0, e.cnt});
                check("pulse_level", {31'd0, flick_level}, 32'd1);
            end
        end
        prev_pulse = pulse_flick;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CNT_W-1:0] c;

        // 1. Reset held for two cycles.
        reset = 1'b0;
        flick = 1'b0;
        repeat (2) tick();
        check("rst_pulse", {31'd0, pulse_flick}, 32'd0);
        check("rst_level", {31'd0, flick_level}, 32'd0);
        check("rst_count", {24'd0, press_count}, 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        // 2. Clean press held 20 cycles.
        flick = 1'b1;
        expect_pulse(cyc + LAT, 8'd1);
        repeat (20) tick();
        check("t2_level", {31'd0, flick_level}, 32'd1);
        check("t2_count", {24'd0, press_count}, 32'd1);
        flick = 1'b0;
        repeat (10) tick();
        check("t2_release", {31'd0, flick_level}, 32'd0);

        // 3. Press of only three sampling edges is filtered.
        flick = 1'b1;
        repeat (3) tick();
        flick = 1'b0;
        repeat (10) begin
            tick();
            check("t3_level", {31'd0, flick_level}, 32'd0);
        end
        check("t3_count", {24'd0, press_count}, 32'd1);

        // 4. Press bounce 1,0,1,0 then steady 1; release bounce 0,1 then steady 0.
        flick = 1'b1; tick();
        flick = 1'b0; tick();
        flick = 1'b1; tick();
        flick = 1'b0; tick();
        flick = 1'b1;
        expect_pulse(cyc + LAT, 8'd2);
        repeat (12) tick();
        check("t4_level_hi", {31'd0, flick_level}, 32'd1);
        flick = 1'b0; tick();
        flick = 1'b1; tick();
        flick = 1'b0; tick();
        check("t4_level_bounce", {31'd0, flick_level}, 32'd1);
        repeat (12) tick();
        check("t4_level_lo", {31'd0, flick_level}, 32'd0);
        check("t4_count", {24'd0, press_count}, 32'd2);

        // 5. Reset during RISE with deb_cnt == 2, button held.
        flick = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        check("t5_pulse", {31'd0, pulse_flick}, 32'd0);
        check("t5_level", {31'd0, flick_level}, 32'd0);
        check("t5_count", {24'd0, press_count}, 32'd0);
        reset = 1'b1;
        expect_pulse(cyc + LAT, 8'd1);
        repeat (12) tick();
        check("t5_count_after", {24'd0, press_count}, 32'd1);
        flick = 1'b0;
        repeat (12) tick();

        // 6. 257 clean presses from a fresh reset: counter wraps to 1.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 257; i++) begin
            c = CNT_W'(i + 1);
            flick = 1'b1;
            expect_pulse(cyc + LAT, c);
            repeat (8) tick();
            flick = 1'b0;
            repeat (8) tick();
        end
        repeat (10) tick();
        check("t6_count_wrap", {24'd0, press_count}, 32'd1);
        check("t6_level", {31'd0, flick_level}, 32'd0);

        // Every expected pulse must have been seen.
        check("sb_drain", q.size(), 32'd0);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            $display("FAIL missing_pulse: got none expected pulse at cycle %0d count %0d", e.at, e.cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
